flags_stack: RTL and testbench

//  Parametrised status-flag register with a LIFO shadow stack for nested interrupts.

---
 rtl/flags_pkg.sv | 6 +
 rtl/flag_shadow_stack.sv | 44 ++++
 rtl/flags_stack.sv | 62 ++++++
 tb/tb_flags_stack.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/flags_pkg.sv
// flags_pkg: shared flag indices and the stack-operation encoding for flags_stack
package flags_pkg;
  localparam int FLG_C = 0;
  localparam int FLG_Z = 1;
  typedef enum logic [1:0] {STK_NONE, STK_PUSH, STK_POP, STK_SWAP} stk_op_t;
endpackage

// File: rtl/flag_shadow_stack.sv
// flag_shadow_stack: DEPTH x NUM_FLAGS LIFO with occupancy counter and top-of-stack read port
module flag_shadow_stack import flags_pkg::*; #(
  parameter int NUM_FLAGS = 2,
  parameter int DEPTH     = 4,
  localparam int DW       = $clog2(DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  stk_op_t              op_i,
  input  logic [NUM_FLAGS-1:0] din_i,
  output logic [NUM_FLAGS-1:0] top_o,
  output logic [DW-1:0]        depth_o,
  output logic                 full_o,
  output logic                 empty_o
);
  logic [NUM_FLAGS-1:0] stk_q [DEPTH];
  logic [NUM_FLAGS-1:0] stk_d [DEPTH];
  logic [DW-1:0]        depth_q, depth_d, top_idx;
  assign top_idx = depth_q - DW'(1);
  always_comb begin
    top_o = '0;
    for (int i = 0; i < DEPTH; i++) top_o = (DW'(i) == top_idx) ? stk_q[i] : top_o;
  end
  // push writes the free slot, swap overwrites the current top
  always_comb begin
    for (int i = 0; i < DEPTH; i++)
      stk_d[i] = ((op_i == STK_PUSH && DW'(i) == depth_q) ||
                  (op_i == STK_SWAP && DW'(i) == top_idx)) ? din_i : stk_q[i];
    depth_d = (op_i == STK_PUSH) ? depth_q + DW'(1) :
              (op_i == STK_POP)  ? depth_q - DW'(1) : depth_q;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stk_q   <= '{default: '0};
      depth_q <= '0;
    end else begin
      stk_q   <= stk_d;
      depth_q <= depth_d;
    end
  end
  assign depth_o = depth_q;
  assign full_o  = (depth_q == DW'(DEPTH));
  assign empty_o = (depth_q == '0);
endmodule

// File: rtl/flags_stack.sv
// flags_stack: status-flag register with per-flag load/set/clear and a LIFO shadow stack for nested interrupts
module flags_stack import flags_pkg::*; #(
  parameter int NUM_FLAGS   = 2,
  parameter int DEPTH       = 4,
  parameter bit CLR_ON_PUSH = 1'b1,
  localparam int DW         = $clog2(DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_FLAGS-1:0] flg_in,
  input  logic [NUM_FLAGS-1:0] flg_ld,
  input  logic [NUM_FLAGS-1:0] flg_set,
  input  logic [NUM_FLAGS-1:0] flg_clr,
  input  logic                 flg_push,
  input  logic                 flg_pop,
  input  logic                 err_clr,
  output logic [NUM_FLAGS-1:0] flg_out,
  output logic [DW-1:0]        depth,
  output logic                 full,
  output logic                 empty,
  output logic                 ovf,
  output logic                 unf
);
  stk_op_t              op;
  logic [NUM_FLAGS-1:0] flg_q, flg_d, ops, top;
  logic                 ovf_q, ovf_d, unf_q, unf_d;
  // push+pop on an empty stack degrades to a plain push
  always_comb begin
    op = (flg_push && flg_pop) ? (empty ? STK_PUSH : STK_SWAP) :
         flg_push              ? (full  ? STK_NONE : STK_PUSH) :
         flg_pop               ? (empty ? STK_NONE : STK_POP)  : STK_NONE;
    ops   = (((flg_ld & flg_in) | (~flg_ld & flg_q)) | flg_set) & ~flg_clr;
    flg_d = (op == STK_POP || op == STK_SWAP)   ? top :
            (op == STK_PUSH && CLR_ON_PUSH)     ? '0  : ops;
    ovf_d = (flg_push && !flg_pop && full)  | (ovf_q & ~err_clr);
    unf_d = (flg_pop && !flg_push && empty) | (unf_q & ~err_clr);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      flg_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      flg_q <= flg_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end
  flag_shadow_stack #(.NUM_FLAGS(NUM_FLAGS), .DEPTH(DEPTH)) u_stk (
    .clk     (clk),
    .rst_n   (rst_n),
    .op_i    (op),
    .din_i   (flg_q),
    .top_o   (top),
    .depth_o (depth),
    .full_o  (full),
    .empty_o (empty)
  );
  assign flg_out = flg_q;
  assign ovf     = ovf_q;
  assign unf     = unf_q;
endmodule

// File: tb/tb_flags_stack.sv
// tb_flags_stack: directed and random checks of flags_stack (CLR_ON_PUSH=1 and 0) against a LIFO reference model
module tb_flags_stack;
  import flags_pkg::*;
  logic       clk = 0;
  logic       rst_n;
  logic [1:0] flg_in, flg_ld, flg_set, flg_clr;
  logic       flg_push, flg_pop, err_clr;
  logic [1:0] fo [2];
  logic [2:0] dp [2];
  logic       fu [2], em [2], ov [2], un [2];
  int checks = 0, failures = 0;
  // reference model: index 0 -> CLR_ON_PUSH=0, index 1 -> CLR_ON_PUSH=1
  logic [1:0] m_f [2];
  logic [1:0] m_s [2][4];
  int         m_d [2];
  logic       m_ovf [2], m_unf [2];

  always #5 clk = ~clk;

  flags_stack #(.NUM_FLAGS(2), .DEPTH(4), .CLR_ON_PUSH(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .flg_in(flg_in), .flg_ld(flg_ld), .flg_set(flg_set),
    .flg_clr(flg_clr), .flg_push(flg_push), .flg_pop(flg_pop), .err_clr(err_clr),
    .flg_out(fo[0]), .depth(dp[0]), .full(fu[0]), .empty(em[0]), .ovf(ov[0]), .unf(un[0]));
  flags_stack #(.NUM_FLAGS(2), .DEPTH(4), .CLR_ON_PUSH(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .flg_in(flg_in), .flg_ld(flg_ld), .flg_set(flg_set),
    .flg_clr(flg_clr), .flg_push(flg_push), .flg_pop(flg_pop), .err_clr(err_clr),
    .flg_out(fo[1]), .depth(dp[1]), .full(fu[1]), .empty(em[1]), .ovf(ov[1]), .unf(un[1]));

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    for (int c = 0; c < 2; c++) begin
      logic [1:0] ops, tmp;
      logic       nov, nun;
      if (!rst_n) begin
        m_f[c] = 0; m_d[c] = 0; m_ovf[c] = 0; m_unf[c] = 0;
        for (int k = 0; k < 4; k++) m_s[c][k] = 0;
        continue;
      end
      for (int b = 0; b < 2; b++)
        ops[b] = flg_clr[b] ? 1'b0 : flg_set[b] ? 1'b1 : flg_ld[b] ? flg_in[b] : m_f[c][b];
      nov = (flg_push && !flg_pop && m_d[c] == 4) ? 1'b1 : err_clr ? 1'b0 : m_ovf[c];
      nun = (flg_pop && !flg_push && m_d[c] == 0) ? 1'b1 : err_clr ? 1'b0 : m_unf[c];
      if (flg_push && flg_pop && m_d[c] > 0) begin
        tmp = m_s[c][m_d[c]-1]; m_s[c][m_d[c]-1] = m_f[c]; m_f[c] = tmp;
      end else if (flg_push && m_d[c] < 4) begin
        m_s[c][m_d[c]] = m_f[c]; m_d[c]++; m_f[c] = (c == 1) ? 2'b00 : ops;
      end else if (flg_pop && !flg_push && m_d[c] > 0) begin
        m_d[c]--; m_f[c] = m_s[c][m_d[c]];
      end else m_f[c] = ops;
      m_ovf[c] = nov; m_unf[c] = nun;
    end
  endtask

  task automatic compare();
    for (int c = 0; c < 2; c++) begin
      chk($sformatf("flg_out[%0d]", c), 8'(fo[c]), 8'(m_f[c]));
      chk($sformatf("depth[%0d]", c), 8'(dp[c]), 8'(m_d[c]));
      chk($sformatf("full[%0d]", c), 8'(fu[c]), 8'(m_d[c] == 4));
      chk($sformatf("empty[%0d]", c), 8'(em[c]), 8'(m_d[c] == 0));
      chk($sformatf("ovf[%0d]", c), 8'(ov[c]), 8'(m_ovf[c]));
      chk($sformatf("unf[%0d]", c), 8'(un[c]), 8'(m_unf[c]));
    end
  endtask

  task automatic step(input logic r, input logic [1:0] in, input logic [1:0] ld,
                      input logic [1:0] st, input logic [1:0] cl,
                      input logic pu, input logic po, input logic ec);
    rst_n = r; flg_in = in; flg_ld = ld; flg_set = st; flg_clr = cl;
    flg_push = pu; flg_pop = po; err_clr = ec;
    @(posedge clk);
    #1;
    model_step();
    compare();
  endtask

  initial begin
    step(0, 2'b11, 2'b11, 2'b11, 2'b00, 1, 1, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    chk("reset_flags", 8'(fo[1]), 8'h0);
    chk("reset_empty", 8'(em[1]), 8'h1);
    step(1, 2'b11, 2'b11, 0, 0, 0, 0, 0);
    chk("ld_both", 8'(fo[1]), 8'h3);
    step(1, 0, 0, 0, 2'b01, 0, 0, 0);
    chk("clr_c", 8'(fo[1]), 8'h2);
    step(1, 0, 0, 2'b01, 2'b01, 0, 0, 0);
    chk("clr_beats_set", 8'(fo[1][FLG_C]), 8'h0);
    step(1, 0, 0, 2'b01, 0, 0, 0, 0);
    chk("set_c", 8'(fo[1][FLG_C]), 8'h1);
    step(1, 0, 0, 0, 2'b10, 0, 0, 0);
    step(1, 0, 0, 0, 0, 1, 0, 0);
    chk("push_clears", 8'(fo[1]), 8'h0);
    chk("push_keeps_noclr", 8'(fo[0]), 8'h1);
    chk("push_depth", 8'(dp[1]), 8'h1);
    step(1, 0, 0, 2'b10, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 1, 0, 0);
    chk("nest_depth", 8'(dp[1]), 8'h2);
    step(1, 0, 0, 0, 0, 0, 1, 0);
    chk("pop_inner", 8'(fo[1]), 8'h2);
    step(1, 0, 0, 0, 0, 0, 1, 0);
    chk("pop_outer", 8'(fo[1]), 8'h1);
    for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 0, 1, 0, 0);
    chk("ovf_set", 8'(ov[1]), 8'h1);
    chk("full_depth", 8'(dp[1]), 8'h4);
    step(1, 0, 0, 0, 0, 0, 0, 1);
    chk("ovf_cleared", 8'(ov[1]), 8'h0);
    for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 0, 0, 1, 0);
    step(1, 0, 0, 0, 0, 0, 1, 0);
    chk("unf_set", 8'(un[1]), 8'h1);
    step(1, 0, 0, 0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0, 1, 1, 0);
    chk("pushpop_empty_depth", 8'(dp[1]), 8'h1);
    chk("pushpop_empty_unf", 8'(un[1]), 8'h0);
    step(1, 2'b10, 2'b11, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 1, 0, 0);
    step(1, 0, 0, 2'b01, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 1, 1, 0);
    chk("swap_flags", 8'(fo[1]), 8'h2);
    chk("swap_depth", 8'(dp[1]), 8'h2);
    step(1, 0, 0, 0, 0, 0, 1, 0);
    chk("swap_top", 8'(fo[1]), 8'h1);
    step(1, 0, 0, 0, 0, 1, 0, 0);
    step(1, 0, 0, 0, 0, 1, 0, 0);
    chk("pre_reset_depth", 8'(dp[1]), 8'h3);
    step(0, 0, 0, 0, 0, 1, 0, 0);
    chk("mid_reset_depth", 8'(dp[1]), 8'h0);
    chk("mid_reset_flags", 8'(fo[0]), 8'h0);
    for (int i = 0; i < 400; i++)
      step(($urandom_range(0, 39) != 0), 2'($urandom), 2'($urandom), 2'($urandom & $urandom),
           2'($urandom & $urandom), ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 7) == 0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
